// File: rtl/demux_pkg.sv
// Shared constants, holding-stage state encoding and decode helper for the 1:4 demux.
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // One-hot decode of a channel select.
  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_OUT-1:0] v;
    v      = {N_OUT{1'b0}};
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_sat_cnt.sv
// Saturating per-channel delivery counter; holds at all-ones instead of wrapping.
module demux_sat_cnt
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count deliveries, stopping at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/one_to_four_demux.sv
// One-entry holding stage routing a beat to one of four channels, dropping beats for disabled channels.
// Define DEMUX_CNT_EN to add the chan_cnt port with four saturating delivery counters.
module one_to_four_demux
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       chan_en,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             drop_pulse
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]      chan_cnt
`endif
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   data_nxt_s;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   sel_nxt_s;
  logic [N_OUT-1:0]   valid_r;
  logic [N_OUT-1:0]   valid_nxt_s;
  logic               drop_r;
  logic               drop_nxt_s;
  logic               in_ready_s;
  logic               deliver_s;
  logic               accept_s;

  // Holding-stage registers; every output is driven from these except in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      data_r  <= {WIDTH{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      valid_r <= {N_OUT{1'b0}};
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      sel_r   <= sel_nxt_s;
      valid_r <= valid_nxt_s;
      drop_r  <= drop_nxt_s;
    end
  end

  // Next-state: an enabled accept wins over delivery so the stage can stream one beat per cycle.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    sel_nxt_s   = sel_r;
    valid_nxt_s = valid_r;
    drop_nxt_s  = 1'b0;
    in_ready_s  = 1'b1;
    deliver_s   = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        in_ready_s = 1'b1;
        deliver_s  = 1'b0;
      end
      ST_FULL: begin
        in_ready_s = out_ready[sel_r];
        deliver_s  = out_ready[sel_r];
      end
      default: begin
        in_ready_s = 1'b1;
        deliver_s  = 1'b0;
      end
    endcase
    accept_s = in_valid && in_ready_s;
    if (accept_s && chan_en[in_sel]) begin
      state_nxt_s = ST_FULL;
      data_nxt_s  = in_data;
      sel_nxt_s   = in_sel;
      valid_nxt_s = onehot(in_sel);
    end else if (deliver_s) begin
      state_nxt_s = ST_EMPTY;
      valid_nxt_s = {N_OUT{1'b0}};
    end else begin
      state_nxt_s = state_r;
    end
    drop_nxt_s = accept_s && !chan_en[in_sel];
  end

  assign in_ready   = in_ready_s;
  assign out_data   = data_r;
  assign out_valid  = valid_r;
  assign drop_pulse = drop_r;

`ifdef DEMUX_CNT_EN
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    demux_sat_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (valid_r[k] & out_ready[k]),
      .cnt   (chan_cnt[CNT_W*k +: CNT_W])
    );
  end
`endif

endmodule
